// File: rtl/sfixed_pkg.sv
// Shared signed fixed-point helpers: width arithmetic, default formats and a
// saturating resize used by the dot-product accumulator.
package sfixed_pkg;

  function automatic int sfx_width(input int left, input int right);
    return left + right + 1;
  endfunction

  // Q3.4 operands feed the multiplier; its products are Q7.8.
  localparam int OPND_LEFT  = 3;
  localparam int OPND_RIGHT = 4;
  localparam int OPND_W     = sfx_width(OPND_LEFT, OPND_RIGHT);
  localparam int PROD_LEFT  = 7;
  localparam int PROD_RIGHT = 8;
  localparam int PROD_W     = sfx_width(PROD_LEFT, PROD_RIGHT);

  localparam int SAT_MAX_W = 64;

  typedef struct packed {
    logic signed [SAT_MAX_W-1:0] value;
    logic                        sat;
  } sfx_sat_t;

  // Clamp a sign-extended value into the signed range of out_w bits.
  function automatic sfx_sat_t sfx_sat(input logic signed [SAT_MAX_W-1:0] value,
                                       input int out_w);
    sfx_sat_t                    res;
    logic signed [SAT_MAX_W-1:0] max_v;
    logic signed [SAT_MAX_W-1:0] min_v;
    res.value = value;
    res.sat   = 1'b0;
    if (out_w < SAT_MAX_W) begin
      max_v = (64'sd1 <<< (out_w - 1)) - 64'sd1;
      min_v = -(64'sd1 <<< (out_w - 1));
      if (value > max_v) begin
        res.value = max_v;
        res.sat   = 1'b1;
      end else if (value < min_v) begin
        res.value = min_v;
        res.sat   = 1'b1;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/sfixed_sat_resize.sv
// Combinational signed clamp from IN_W to OUT_W bits with a saturation flag.
module sfixed_sat_resize
  import sfixed_pkg::*;
#(
  parameter int IN_W  = 22,
  parameter int OUT_W = 21
) (
  input  logic signed [IN_W-1:0]  in_val,
  output logic signed [OUT_W-1:0] out_val,
  output logic                    out_sat
);

  sfx_sat_t w_res;
  logic     w_unused;

  assign w_res    = sfx_sat(SAT_MAX_W'(in_val), OUT_W);
  assign out_val  = w_res.value[OUT_W-1:0];
  assign out_sat  = w_res.sat;
  // Upper bits are pure sign extension of the clamped result.
  assign w_unused = ^w_res.value[SAT_MAX_W-1:OUT_W];

endmodule

// File: rtl/sfixed_dot2_acc.sv
// Two-lane signed fixed-point dot-product accumulator: pair-sum stage, then a
// saturating accumulator that emits one result per in_last-delimited vector.
module sfixed_dot2_acc
  import sfixed_pkg::*;
#(
  parameter int IN_LEFT   = PROD_LEFT,
  parameter int IN_RIGHT  = PROD_RIGHT,
  parameter int OUT_LEFT  = 7,
  parameter int ACC_GUARD = 4,
  parameter int CNT_W     = 8
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic                                in_last,
  input  logic signed [IN_LEFT+IN_RIGHT:0]    in_x,
  input  logic signed [IN_LEFT+IN_RIGHT:0]    in_y,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic signed [OUT_LEFT+IN_RIGHT:0]   out_acc,
  output logic                                out_sat,
  output logic        [CNT_W-1:0]             out_count
);

  localparam int IN_W  = sfx_width(IN_LEFT, IN_RIGHT);
  localparam int SUM_W = IN_W + 1;
  localparam int ACC_W = SUM_W + ACC_GUARD;
  localparam int OUT_W = sfx_width(OUT_LEFT, IN_RIGHT);

  logic                    w_stall;
  logic                    w_accept;
  logic signed [SUM_W-1:0] r_sum;
  logic                    r_sum_v;
  logic                    r_sum_last;
  logic signed [ACC_W-1:0] r_acc;
  logic        [CNT_W-1:0] r_cnt;
  logic                    r_sat_acc;
  logic signed [ACC_W:0]   w_acc_wide;
  logic signed [ACC_W-1:0] w_nxt;
  logic                    w_acc_clamp;
  logic signed [OUT_W-1:0] w_out_val;
  logic                    w_out_clamp;
  logic        [CNT_W-1:0] w_cnt_inc;

  assign w_stall  = out_valid && !out_ready;
  assign in_ready = !w_stall;
  assign w_accept = in_valid && in_ready;

  // Stage A: sign-extended lane sum.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      r_sum      <= '0;
      r_sum_v    <= 1'b0;
      r_sum_last <= 1'b0;
    end else if (w_accept) begin
      r_sum      <= SUM_W'(in_x) + SUM_W'(in_y);
      r_sum_v    <= 1'b1;
      r_sum_last <= in_last;
    end else if (!w_stall) begin
      r_sum_v <= 1'b0;
    end
  end

  assign w_acc_wide = (ACC_W+1)'(r_acc) + (ACC_W+1)'(r_sum);
  assign w_cnt_inc  = (&r_cnt) ? r_cnt : r_cnt + CNT_W'(1);

  sfixed_sat_resize #(.IN_W(ACC_W + 1), .OUT_W(ACC_W)) u_acc_clamp (
    .in_val  (w_acc_wide),
    .out_val (w_nxt),
    .out_sat (w_acc_clamp)
  );

  sfixed_sat_resize #(.IN_W(ACC_W), .OUT_W(OUT_W)) u_out_clamp (
    .in_val  (w_nxt),
    .out_val (w_out_val),
    .out_sat (w_out_clamp)
  );

  // Stage B: accumulate, and on the last beat publish and restart.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc     <= '0;
      r_cnt     <= '0;
      r_sat_acc <= 1'b0;
      out_valid <= 1'b0;
      out_acc   <= '0;
      out_sat   <= 1'b0;
      out_count <= '0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      if (r_sum_v && !w_stall) begin
        if (r_sum_last) begin
          // A completing vector overrides the handshake clear above.
          out_acc   <= w_out_val;
          out_sat   <= r_sat_acc | w_acc_clamp | w_out_clamp;
          out_count <= w_cnt_inc;
          out_valid <= 1'b1;
          r_acc     <= '0;
          r_cnt     <= '0;
          r_sat_acc <= 1'b0;
        end else begin
          r_acc     <= w_nxt;
          r_cnt     <= w_cnt_inc;
          r_sat_acc <= r_sat_acc | w_acc_clamp;
        end
      end
    end
  end

endmodule

// File: tb/tb_sfixed_dot2_acc.sv
// Scoreboard bench for sfixed_dot2_acc with directed, hand-computed vectors.
module tb_sfixed_dot2_acc;

  typedef struct packed {
    logic [15:0] acc;
    logic        sat;
    logic [7:0]  cnt;
  } exp_t;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic               in_last;
  logic signed [15:0] in_x;
  logic signed [15:0] in_y;
  logic               out_valid;
  logic               out_ready;
  logic signed [15:0] out_acc;
  logic               out_sat;
  logic [7:0]         out_count;

  int   checks = 0;
  int   errors = 0;
  exp_t q[$];

  logic        prev_stall = 1'b0;
  logic [15:0] held_acc;
  logic        held_sat;
  logic [7:0]  held_cnt;

  sfixed_dot2_acc dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_last   (in_last),
    .in_x      (in_x),
    .in_y      (in_y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_acc   (out_acc),
    .out_sat   (out_sat),
    .out_count (out_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one beat and hold it until it is accepted (bounded).
  task automatic send(input logic [15:0] x, input logic [15:0] y, input logic last);
    logic rdy;
    int   n;
    in_valid = 1'b1;
    in_x     = x;
    in_y     = y;
    in_last  = last;
    n        = 0;
    do begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      n++;
    end while (!rdy && n < 100);
    if (!rdy) check("send_timeout", 32'(n), 32'd0);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic push(input logic [15:0] acc, input logic sat, input logic [7:0] cnt);
    exp_t e;
    e.acc = acc;
    e.sat = sat;
    e.cnt = cnt;
    q.push_back(e);
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    check("drain_queue", 32'(q.size()), 32'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 50);
    check(name, {31'd0, out_valid}, 32'd1);
  endtask

  // Monitor: pops the scoreboard on every output handshake.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      check("in_ready_vs_stall", {31'd0, in_ready}, {31'd0, !(out_valid && !out_ready)});
      if (prev_stall) begin
        check("held_acc", {16'd0, out_acc}, {16'd0, held_acc});
        check("held_sat", {31'd0, out_sat}, {31'd0, held_sat});
        check("held_count", {24'd0, out_count}, {24'd0, held_cnt});
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          check("unexpected_result", {16'd0, out_acc}, 32'hFFFF_FFFF);
        end else begin
          e = q.pop_front();
          check("out_acc", {16'd0, out_acc}, {16'd0, e.acc});
          check("out_sat", {31'd0, out_sat}, {31'd0, e.sat});
          check("out_count", {24'd0, out_count}, {24'd0, e.cnt});
        end
      end
      prev_stall = out_valid && !out_ready;
      held_acc   = out_acc;
      held_sat   = out_sat;
      held_cnt   = out_count;
    end else begin
      prev_stall = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    in_x      = '0;
    in_y      = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_acc", {16'd0, out_acc}, 32'd0);
    check("rst_out_sat", {31'd0, out_sat}, 32'd0);
    check("rst_out_count", {24'd0, out_count}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // 3-beat vector: 1.75 + 0 + 1.0 = 2.75
    push(16'h02C0, 1'b0, 8'd3);
    send(16'h0180, 16'h0040, 1'b0);
    send(16'h0100, 16'hFF00, 1'b0);
    send(16'h0080, 16'h0080, 1'b1);
    check("latency_edge1", {31'd0, out_valid}, 32'd0);
    @(posedge clk);
    #1;
    check("latency_edge2", {31'd0, out_valid}, 32'd1);
    drain();

    // Positive and negative saturation, then sticky flag cleared.
    push(16'h7FFF, 1'b1, 8'd2);
    send(16'h7FFF, 16'h7FFF, 1'b0);
    send(16'h7FFF, 16'h7FFF, 1'b1);
    push(16'h8000, 1'b1, 8'd2);
    send(16'h8000, 16'h8000, 1'b0);
    send(16'h8000, 16'h8000, 1'b1);
    push(16'h0100, 1'b0, 8'd1);
    send(16'h0100, 16'h0000, 1'b1);
    drain();

    // Backpressure: hold the first result while the next vector streams.
    out_ready = 1'b0;
    push(16'h0030, 1'b0, 8'd1);
    push(16'h03C0, 1'b0, 8'd3);
    fork
      begin
        send(16'h0010, 16'h0020, 1'b1);
        send(16'h0100, 16'h0100, 1'b0);
        send(16'h0200, 16'h0000, 1'b0);
        send(16'hFFC0, 16'h0000, 1'b1);
      end
      begin
        wait_valid("bp_first_valid");
        repeat (5) begin
          @(negedge clk);
          check("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Back-to-back single-beat vectors: out_valid must not drop.
    push(16'h0003, 1'b0, 8'd1);
    push(16'h0030, 1'b0, 8'd1);
    push(16'h7FFF, 1'b1, 8'd1);
    push(16'hFFFE, 1'b0, 8'd1);
    fork
      begin
        send(16'h0001, 16'h0002, 1'b1);
        send(16'h0010, 16'h0020, 1'b1);
        send(16'h7FFF, 16'h0001, 1'b1);
        send(16'hFFFF, 16'hFFFF, 1'b1);
      end
      begin
        wait_valid("b2b_first_valid");
        repeat (3) begin
          @(negedge clk);
          check("b2b_valid_held", {31'd0, out_valid}, 32'd1);
        end
      end
    join
    drain();

    // Reset mid-vector discards the partial vector.
    send(16'h0100, 16'h0100, 1'b0);
    send(16'h0100, 16'h0100, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_out_acc", {16'd0, out_acc}, 32'd0);
    check("mid_rst_out_sat", {31'd0, out_sat}, 32'd0);
    check("mid_rst_out_count", {24'd0, out_count}, 32'd0);
    check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    push(16'h0080, 1'b0, 8'd1);
    send(16'h0040, 16'h0040, 1'b1);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
